// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction-fetch front end. It issues pipelined requests to a
//            req/gnt/rvalid instruction memory and can keep up to
//            MAX_OUTSTANDING requests in flight. Returned instructions go into
//            a DEPTH-entry in-order queue, and decode takes them over a
//            valid/ready handshake. A redirect flushes the queue and drops any
//            responses that are still in flight.
//
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            redirect_valid - taken branch/jump redirect from EX
//            redirect_pc    - redirect target (bits [1:0] ignored)
//            imem_req       - fetch request valid
//            imem_addr      - fetch address, 4-byte aligned
//            imem_gnt       - memory accepted the request this cycle
//            imem_rvalid    - response valid (in order, >=1 cycle after gnt)
//            imem_rdata     - response instruction
//            out_valid      - queue head valid
//            out_pc         - PC of the head instruction
//            out_instr      - head instruction
//            out_ready      - decode accepts the head
//
// Options  : FETCH_BYPASS_EN - when the queue is empty, a live response is
//            presented to decode combinationally in the same cycle. If it is
//            consumed there, it never enters the queue.
//
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int              XLEN            = 64,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  input  logic            out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);
  localparam logic [XLEN-1:0] c_align_msk = ~XLEN'(3);
  localparam logic [OW-1:0]   c_max_out   = OW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     c_depth     = (CW + 1)'(DEPTH);
  localparam logic [OW-1:0]   c_one_o     = OW'(1);
  localparam logic [CW-1:0]   c_one_c     = CW'(1);
  localparam logic [AW-1:0]   c_one_a     = AW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q,  discard_d;
  logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [CW:0]     w_occupancy;
  logic            w_grant;
  logic            w_discarding;
  logic            w_rsp_keep;
  logic            w_bypass;
  logic            w_bypass_take;
  logic            w_push;
  logic            w_pop;
  logic            w_q_valid;
  logic [XLEN-1:0] w_redirect_pc;

  // Every request in flight has a queue slot reserved for it, so a response
  // can always be pushed.
  assign w_occupancy = {1'b0, count_q} + (CW + 1)'(outstanding_q);

  // Gating with rst_n keeps the request low while reset is held. The state is
  // cleared during reset, so without this the credit check alone would raise
  // the request.
  assign imem_req  = rst_n && !redirect_valid &&
                     (outstanding_q < c_max_out) && (w_occupancy < c_depth);
  assign imem_addr = fetch_pc_q;

  assign w_grant       = imem_req && imem_gnt;
  assign w_discarding  = (discard_q != '0);
  assign w_rsp_keep    = imem_rvalid && !w_discarding;
  assign w_redirect_pc = redirect_pc & c_align_msk;
  assign w_q_valid     = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = rst_n && !w_q_valid && w_rsp_keep && !redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed response that decode takes at once never occupies a slot.
  assign w_bypass_take = w_bypass && out_ready;
  assign w_push        = w_rsp_keep && !redirect_valid && !w_bypass_take;
  assign w_pop         = w_q_valid && out_ready && !redirect_valid;

  assign out_valid = w_q_valid || w_bypass;
  assign out_pc    = w_bypass ? resp_pc_q  : pc_mem_q[rd_ptr_q];
  assign out_instr = w_bypass ? imem_rdata : instr_mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    // A response always retires one outstanding request, even when it is
    // being discarded. A grant and a response in the same cycle cancel out.
    if (w_grant && !imem_rvalid) begin
      outstanding_d = outstanding_q + c_one_o;
    end else if (!w_grant && imem_rvalid) begin
      outstanding_d = outstanding_q - c_one_o;
    end

    if (redirect_valid) begin
      fetch_pc_d = w_redirect_pc;
      resp_pc_d  = w_redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still in flight is stale. Outstanding already counts
      // requests that an earlier redirect marked for discard, so repeated
      // redirects add up correctly. A response in this same cycle is dropped
      // here and needs no discard credit.
      discard_d  = imem_rvalid ? (outstanding_q - c_one_o) : outstanding_q;
    end else begin
      if (w_grant) begin
        fetch_pc_d = fetch_pc_q + c_pc_step;
      end
      if (imem_rvalid && w_discarding) begin
        discard_d = discard_q - c_one_o;
      end
      if (w_rsp_keep) begin
        resp_pc_d = resp_pc_q + c_pc_step;
      end
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + c_one_a;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_one_a;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + c_one_c;
      end else if (!w_push && w_pop) begin
        count_d = count_q - c_one_c;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // The queue storage is reset so that out_pc/out_instr read as zero after
  // reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (w_push) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire
